// File: rtl/scan_code_frame_tx.sv
// Scan-code link transmitter: accepts a byte on valid/ready and serialises
// start, D0..D7 (LSB first), parity and stop on an idle-high line.
module scan_code_frame_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code_in,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       frame_done
);

    // state    | meaning
    // S_IDLE   | line high, ready for a byte
    // S_START  | start bit (0)
    // S_DATA   | data bits D0..D7, LSB first
    // S_PARITY | parity bit
    // S_STOP   | stop bit (1), frame_done on its last cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [8:0]  shift_q, shift_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_ready_q, tx_ready_d;
    logic        tx_busy_q, tx_busy_d;
    logic        frame_done_q, frame_done_d;

    logic        baud_tc;
    logic        parity_bit;
    logic [15:0] baud_next;

    assign baud_tc    = (baud_q == BAUD_LAST);
    assign baud_next  = baud_tc ? 16'd0 : baud_q + 16'd1;
    assign parity_bit = (PARITY_ODD != 0) ? ~^scan_code_in : ^scan_code_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            baud_q       <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 9'd0;
            tx_line_q    <= 1'b1;
            tx_ready_q   <= 1'b0;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_line_q    <= tx_line_d;
            tx_ready_q   <= tx_ready_d;
            tx_busy_q    <= tx_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_line_d  = tx_line_q;
        tx_ready_d = tx_ready_q;
        tx_busy_d  = tx_busy_q;

        case (state_q)
            S_IDLE: begin
                baud_d     = 16'd0;
                bit_idx_d  = 3'd0;
                tx_line_d  = 1'b1;
                tx_ready_d = 1'b1;
                tx_busy_d  = 1'b0;
                // Accept needs the registered ready, so one idle cycle always
                // separates a stop bit from the next start bit.
                if (tx_valid && tx_ready_q) begin
                    state_d    = S_START;
                    shift_d    = {parity_bit, scan_code_in};
                    tx_line_d  = 1'b0;
                    tx_ready_d = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            S_START: begin
                baud_d = baud_next;
                if (baud_tc) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_line_d = shift_q[0];
                    shift_d   = {1'b0, shift_q[8:1]};
                end
            end
            S_DATA: begin
                baud_d = baud_next;
                if (baud_tc) begin
                    // After the last data bit the parity sits in shift_q[0].
                    bit_idx_d = bit_idx_q + 3'd1;
                    tx_line_d = shift_q[0];
                    shift_d   = {1'b0, shift_q[8:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                baud_d = baud_next;
                if (baud_tc) begin
                    state_d   = S_STOP;
                    tx_line_d = 1'b1;
                end
            end
            S_STOP: begin
                baud_d    = baud_next;
                tx_line_d = 1'b1;
                if (baud_tc) begin
                    state_d    = S_IDLE;
                    tx_ready_d = 1'b1;
                    tx_busy_d  = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_d     = 16'd0;
                tx_line_d  = 1'b1;
                tx_ready_d = 1'b0;
                tx_busy_d  = 1'b0;
            end
        endcase

        frame_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    end

    assign tx_ready   = tx_ready_q;
    assign tx_line    = tx_line_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;

endmodule
